mem_port_arbiter: RTL and testbench

- Shares the single external memory port between two requesters: port 0 (data cache refill/writeback) and port 1 (instruction cache refill).
- Sequences each transaction with a small FSM and routes address, write data and write-enable to the memory port.
- Drives a 2-bit select in the codebase mux encoding: 2'b00 = port 0, 2'b01 = port 1, any other value = idle/zero.
- Returns read data and a one-cycle completion pulse to the granted requester.

---
 rtl/mem_port_arbiter_if.sv | 29 ++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle for mem_port_arbiter: both requester ports plus the shared memory port.
// master = the arbiter's view, slave = the requesters/memory environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic                  req0, we0, ready0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  req1, we1, ready1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  mem_req, mem_we, mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  logic [1:0]            sel;
  logic                  busy;

  modport master (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_ready, mem_rdata,
    output ready0, ready1, rdata, mem_req, mem_we, mem_addr, mem_wdata, sel, busy
  );

  modport slave (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_ready, mem_rdata,
    input  ready0, ready1, rdata, mem_req, mem_we, mem_addr, mem_wdata, sel, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the D-cache (port 0) and
// I-cache (port 1). One transaction at a time: IDLE -> BUSYx -> DONE -> IDLE.
// All outputs are registered. sel uses the mux encoding 00/01 = port, 10 = none.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: on a tie the port not last granted
// wins; otherwise port 0 always wins a tie.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  localparam logic [1:0] SEL_P0   = 2'b00;
  localparam logic [1:0] SEL_P1   = 2'b01;
  localparam logic [1:0] SEL_NONE = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, DONE} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t state, state_nxt;
  logic   gnt;       // grant issued on this edge
  logic   gnt_port;  // winning port (valid with gnt)
  logic   done;      // completion sampled on this edge
  logic   tie_p1;    // port 1 wins a tie
  req_t   win_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr_ptr;  // last granted port

  // Remember the last winner so the other port takes the next tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    rr_ptr <= 1'b0;
    else if (gnt) rr_ptr <= gnt_port;
  end

  assign tie_p1 = ~rr_ptr;
`else
  assign tie_p1 = 1'b0;
`endif

  // A lone request always wins; a tie is resolved by tie_p1.
  always_comb begin
    gnt_port = bus.req1 & (~bus.req0 | tie_p1);
    win_req  = gnt_port ? req_t'{bus.we1, bus.addr1, bus.wdata1}
                        : req_t'{bus.we0, bus.addr0, bus.wdata0};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state plus grant/completion strobes; DONE ignores everything.
  always_comb begin
    state_nxt = state;
    gnt       = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          gnt       = 1'b1;
          state_nxt = gnt_port ? BUSY1 : BUSY0;
        end
      end
      BUSY0, BUSY1: begin
        if (bus.mem_ready) begin
          done      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs: latch the winner on grant, hold through BUSY,
  // release the port and pulse the owner's ready on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.rdata     <= '0;
      bus.ready0    <= 1'b0;
      bus.ready1    <= 1'b0;
      bus.sel       <= SEL_NONE;
      bus.busy      <= 1'b0;
    end else begin
      bus.ready0 <= 1'b0;
      bus.ready1 <= 1'b0;
      bus.busy   <= (state_nxt != IDLE);
      if (gnt) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= win_req.we;
        bus.mem_addr  <= win_req.addr;
        bus.mem_wdata <= win_req.wdata;
        bus.sel       <= gnt_port ? SEL_P1 : SEL_P0;
      end
      if (done) begin
        bus.mem_req <= 1'b0;
        bus.mem_we  <= 1'b0;
        bus.sel     <= SEL_NONE;
        bus.rdata   <= bus.mem_rdata;  // also on writes; requester ignores it
        bus.ready0  <= (state == BUSY0);
        bus.ready1  <= (state == BUSY1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Stimulus pushes expected grants and
// completions into queues; a negedge monitor pops and compares them whenever
// the DUT raises mem_req or a ready pulse.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]    sel;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_t;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] rdata;
  } cpl_t;

  gnt_t gnt_q[$];
  cpl_t cpl_q[$];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] last_rdata = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: check every grant and every completion against the queues.
  logic          prev_req = 1'b0;
  logic [AW-1:0] held_addr;
  gnt_t          mg;
  cpl_t          mc;
  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (bus.mem_req && !prev_req) begin
        if (gnt_q.size() == 0) begin
          chk("grant_unexpected", 1, 0);
        end else begin
          mg = gnt_q.pop_front();
          chk("grant_sel",   bus.sel,       mg.sel);
          chk("grant_we",    bus.mem_we,    mg.we);
          chk("grant_addr",  bus.mem_addr,  mg.addr);
          chk("grant_wdata", bus.mem_wdata, mg.wdata);
          held_addr = bus.mem_addr;
        end
      end else if (bus.mem_req && prev_req) begin
        chk("addr_stable", bus.mem_addr, held_addr);
      end
      if (bus.ready0 || bus.ready1) begin
        if (cpl_q.size() == 0) begin
          chk("ready_unexpected", {bus.ready1, bus.ready0}, 0);
        end else begin
          mc = cpl_q.pop_front();
          chk("cpl_port",     bus.ready1,              mc.port);
          chk("cpl_one_hot",  bus.ready0 & bus.ready1, 0);
          chk("cpl_rdata",    bus.rdata,               mc.rdata);
        end
      end
      prev_req = bus.mem_req;
    end
  end

  // One transaction: expected winner 'port' (both=1 raises both requests),
  // mem_ready after n BUSY cycles, optional spurious mem_ready in DONE.
  task automatic txn(input bit both, input bit port, input bit we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [DW-1:0] rd, input int n,
                     input bit spur_done);
    int lat, k;
    gnt_q.push_back('{port ? 2'b01 : 2'b00, we, addr, wdata});
    cpl_q.push_back('{port, rd});
    if (!port) begin
      bus.we0 = we;  bus.addr0 = addr;  bus.wdata0 = wdata;
      bus.we1 = ~we; bus.addr1 = addr ^ 32'hFFFF_0000; bus.wdata1 = ~wdata;
    end else begin
      bus.we1 = we;  bus.addr1 = addr;  bus.wdata1 = wdata;
      bus.we0 = ~we; bus.addr0 = addr ^ 32'hFFFF_0000; bus.wdata0 = ~wdata;
    end
    bus.req0 = !port || both;
    bus.req1 = port || both;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.mem_req && lat < 20);
    chk("grant_latency", lat, 1);
    repeat (n - 1) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rd;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    k = 0;
    while (!(port ? bus.ready1 : bus.ready0) && k < 10) begin
      @(posedge clk); #1; k++;
    end
    chk("ready_seen", port ? bus.ready1 : bus.ready0, 1);
    chk("busy_in_done", bus.busy, 1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    if (spur_done) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = ~rd;
    end
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    chk("idle_busy",   bus.busy,                0);
    chk("idle_sel",    bus.sel,                 2'b10);
    chk("ready_width", bus.ready0 | bus.ready1, 0);
    chk("rdata_hold",  bus.rdata,               rd);
    last_rdata = rd;
  endtask

  bit exp_win[4];

  initial begin
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;

    // Reset held with both requests active: outputs stay at reset values.
    repeat (3) begin
      @(negedge clk);
      chk("rst_sel",     bus.sel,                 2'b10);
      chk("rst_mem_req", bus.mem_req,             0);
      chk("rst_ready",   bus.ready0 | bus.ready1, 0);
      chk("rst_busy",    bus.busy,                0);
      chk("rst_rdata",   bus.rdata,               0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Port 0 line write, mem_ready after 3 BUSY cycles.
    txn(0, 0, 1, 32'h0000_1000, {16{8'hA5}}, 128'h1234_5678, 3, 0);
    // Port 1 read, single BUSY cycle, spurious mem_ready in DONE.
    txn(0, 1, 0, 32'h0000_0040, '0, 128'hDEAD_BEEF, 1, 1);

    // Spurious mem_ready while IDLE.
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'hBAD0_BAD0;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    chk("spur_idle_busy",  bus.busy,                0);
    chk("spur_idle_ready", bus.ready0 | bus.ready1, 0);
    chk("spur_idle_rdata", bus.rdata,               last_rdata);
    chk("spur_idle_req",   bus.mem_req,             0);

    // Reset during the second BUSY1 cycle.
    gnt_q.push_back('{2'b01, 1'b0, 32'h0000_0080, 128'h0});
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h0000_0080; bus.wdata1 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy_before", bus.busy, 1);
    reset = 1'b1;
    bus.req1 = 1'b0;
    #1;
    chk("mid_rst_mem_req", bus.mem_req, 0);
    chk("mid_rst_sel",     bus.sel,     2'b10);
    chk("mid_rst_busy",    bus.busy,    0);
    chk("mid_rst_rdata",   bus.rdata,   0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_rdata = '0;
    txn(0, 0, 0, 32'h0000_2000, '0, 128'hCAFE_F00D, 2, 0);

    // Contention: both request each round; the loser withdraws afterwards.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_win = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_win = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      txn(1, exp_win[i], i[0], 32'h0000_3000 + 32'(i * 16), {4{32'h0101_0101 * (i + 1)}},
          128'hF000 + 128'(i), 1 + i, 0);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    chk("gnt_q_drained", gnt_q.size(), 0);
    chk("cpl_q_drained", cpl_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
